// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer. Each entry has a 2-bit saturating
// direction counter. Lookup happens in the fetch stage and is purely
// combinational. A single resolve port updates the table on the next rising
// edge. The same port reports a mispredict and the redirect address
// combinationally.
//
// Ports
//   clk                 clock, all state changes on the rising edge
//   reset               synchronous, active-high
//   lookup_pc           fetch-stage PC
//   take_branch         predict taken for lookup_pc
//   branch_predict      predicted next fetch address
//   update_valid        a conditional branch resolved this cycle
//   update_pc           address of the resolved branch
//   update_taken        actual outcome
//   update_target       actual taken target
//   update_pred_taken   prediction carried down the pipe with the branch
//   update_pred_target  target carried down the pipe with the branch
//   flush               mispredict, the PC must redirect
//   branch_address      redirect address, meaningful only while flush=1
//   branch_count        resolved-branch counter (wraps)
//   mispredict_count    mispredict counter (wraps)
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int ADDR_WIDTH = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  take_branch,
  output logic [ADDR_WIDTH-1:0] branch_predict,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_pred_taken,
  input  logic [ADDR_WIDTH-1:0] update_pred_target,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] branch_address,
  output logic [15:0]           branch_count,
  output logic [15:0]           mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 1;

  typedef logic [INDEX_BITS-1:0] index_t;
  typedef logic [TAG_W-1:0]      tag_t;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;

  logic                  valid_q  [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  tag_t                  tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];

  // Bit 0 is dropped because instructions are 2-byte aligned.
  index_t lookup_idx;
  tag_t   lookup_tag;
  index_t update_idx;
  tag_t   update_tag;
  logic   lookup_hit;
  logic   update_hit;
  logic   update_en;
  logic [1:0] ctr_next;

  assign lookup_idx = lookup_pc[INDEX_BITS:1];
  assign lookup_tag = lookup_pc[ADDR_WIDTH-1:INDEX_BITS+1];
  assign update_idx = update_pc[INDEX_BITS:1];
  assign update_tag = update_pc[ADDR_WIDTH-1:INDEX_BITS+1];

  // ---------------- lookup ----------------
  // The arrays are read here before the edge, so a same-cycle update to the
  // same index is only visible to the lookup in the following cycle.
  assign lookup_hit     = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign take_branch    = lookup_hit && ctr_q[lookup_idx][1];
  assign branch_predict = take_branch ? target_q[lookup_idx]
                                      : lookup_pc + ADDR_WIDTH'(2);

  // ---------------- resolve ----------------
  assign update_en  = update_valid && !reset;
  assign update_hit = valid_q[update_idx] && (tag_q[update_idx] == update_tag);

  assign flush = update_en &&
                 ((update_taken != update_pred_taken) ||
                  (update_taken && (update_target != update_pred_target)));

  assign branch_address = update_taken ? update_target
                                       : update_pc + ADDR_WIDTH'(2);

  // Saturating step of the resolved entry's counter.
  always_comb begin
    ctr_next = ctr_q[update_idx];
    if (update_taken && ctr_q[update_idx] != 2'b11) begin
      ctr_next = ctr_q[update_idx] + 2'd1;
    end else if (!update_taken && ctr_q[update_idx] != 2'b00) begin
      ctr_next = ctr_q[update_idx] - 2'd1;
    end
  end

  // Valid bits and counters carry the reset state.
  // NOTE: sequential state uses non-blocking assignments so that every read
  // in this cycle sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WEAK_NT;
      end
    end else if (update_en) begin
      if (update_hit) begin
        ctr_q[update_idx] <= ctr_next;
      end else if (update_taken) begin
        valid_q[update_idx] <= 1'b1;
        ctr_q[update_idx]   <= CTR_WEAK_T;
      end
    end
  end

  // NOTE: tag and target storage is deliberately not reset. A cleared valid
  // bit makes its contents irrelevant, so it can map to plain RAM.
  // Both a hit and an allocation write the same fields when the branch is
  // taken. On a hit the tag is rewritten with its existing value.
  always_ff @(posedge clk) begin
    if (update_en && update_taken) begin
      tag_q[update_idx]    <= update_tag;
      target_q[update_idx] <= update_target;
    end
  end

  // ---------------- statistics ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (update_en) begin
      branch_count <= branch_count + 16'd1;
      if (flush) begin
        mispredict_count <= mispredict_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// The stimulus process drives one cycle at a time, just after each rising
// edge. It pushes the expected outputs for that cycle into a queue and then
// advances a behavioural table model. A separate monitor pops one entry on
// every falling edge and compares it with the DUT outputs. The directed
// steps pin literal expected values. The random phase relies on the model.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int AW  = 16;
  localparam int IB  = 4;
  localparam int NUM = 1 << IB;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] lookup_pc;
  logic          take_branch;
  logic [AW-1:0] branch_predict;
  logic          update_valid;
  logic [AW-1:0] update_pc;
  logic          update_taken;
  logic [AW-1:0] update_target;
  logic          update_pred_taken;
  logic [AW-1:0] update_pred_target;
  logic          flush;
  logic [AW-1:0] branch_address;
  logic [15:0]   branch_count;
  logic [15:0]   mispredict_count;

  branch_predictor #(.ADDR_WIDTH(AW), .INDEX_BITS(IB)) dut (
    .clk                (clk),
    .reset              (reset),
    .lookup_pc          (lookup_pc),
    .take_branch        (take_branch),
    .branch_predict     (branch_predict),
    .update_valid       (update_valid),
    .update_pc          (update_pc),
    .update_taken       (update_taken),
    .update_target      (update_target),
    .update_pred_taken  (update_pred_taken),
    .update_pred_target (update_pred_target),
    .flush              (flush),
    .branch_address     (branch_address),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    string   name;
    bit      tb;
    int      bp;
    bit      fl;
    int      ba;
    int      bc;
    int      mc;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act == want) passed++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, want);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".take_branch"},      int'(take_branch),      int'(e.tb));
      check({e.name, ".branch_predict"},   int'(branch_predict),   e.bp);
      check({e.name, ".flush"},            int'(flush),            int'(e.fl));
      if (e.fl) check({e.name, ".branch_address"}, int'(branch_address), e.ba);
      check({e.name, ".branch_count"},     int'(branch_count),     e.bc);
      check({e.name, ".mispredict_count"}, int'(mispredict_count), e.mc);
    end
  end

  // ---------------- reference model ----------------
  // The model works on whole entries with integer arithmetic. The index is
  // (pc/2) mod NUM, the tag is pc / 2^(IB+1), and ctr is an int clamped
  // to 0..3.
  bit m_valid [NUM];
  int m_tag   [NUM];
  int m_tgt   [NUM];
  int m_ctr   [NUM];
  int m_bc, m_mc;

  function automatic int idx_of(input int pc); return (pc / 2) % NUM; endfunction
  function automatic int tag_of(input int pc); return pc / (1 << (IB + 1)); endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endfunction

  function automatic void predict(input int pc, output bit t, output int p);
    int i;
    i = idx_of(pc);
    t = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    p = t ? m_tgt[i] : (pc + 2) % 65536;
  endfunction

  // Drive one cycle, push its expectation, then apply the edge to the model.
  task automatic step(input string name, input bit rst, input int lpc,
                      input bit uv, input int upc, input bit ut, input int utgt,
                      input bit upt, input int uptgt);
    exp_t e;
    int   i;
    @(posedge clk);
    #1;
    reset              = rst;
    lookup_pc          = AW'(lpc);
    update_valid       = uv;
    update_pc          = AW'(upc);
    update_taken       = ut;
    update_target      = AW'(utgt);
    update_pred_taken  = upt;
    update_pred_target = AW'(uptgt);

    e.name = name;
    predict(lpc, e.tb, e.bp);
    e.fl = !rst && uv && ((ut != upt) || (ut && utgt != uptgt));
    e.ba = ut ? utgt : (upc + 2) % 65536;
    e.bc = m_bc;
    e.mc = m_mc;
    exp_q.push_back(e);

    if (rst) begin
      model_reset();
    end else if (uv) begin
      m_bc = (m_bc + 1) % 65536;
      if (e.fl) m_mc = (m_mc + 1) % 65536;
      i = idx_of(upc);
      if (m_valid[i] && m_tag[i] == tag_of(upc)) begin
        m_ctr[i] = ut ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                      : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (ut) m_tgt[i] = utgt;
      end else if (ut) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(upc);
        m_tgt[i]   = utgt;
        m_ctr[i]   = 2;
      end
    end
  endtask

  // Replace the most recent expectation with literal values.
  task automatic pin(input bit t, input int p, input bit f, input int a);
    exp_q[exp_q.size()-1].tb = t;
    exp_q[exp_q.size()-1].bp = p;
    exp_q[exp_q.size()-1].fl = f;
    exp_q[exp_q.size()-1].ba = a;
  endtask

  task automatic pin_cnt(input int bc, input int mc);
    exp_q[exp_q.size()-1].bc = bc;
    exp_q[exp_q.size()-1].mc = mc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; lookup_pc = '0; update_valid = 1'b0; update_pc = '0;
    update_taken = 1'b0; update_target = '0; update_pred_taken = 1'b0;
    update_pred_target = '0;
    model_reset();
    repeat (3) @(posedge clk);

    //     name          rst lpc      uv upc      ut tgt      pt ptgt
    step("post_reset",   0, 'h0040,  0, 'h0000,  0, 'h0000,  0, 'h0000); pin(0, 'h0042, 0, 0);
    step("alloc",        0, 'h0040,  1, 'h0040,  1, 'h0100,  0, 'h0000); pin(0, 'h0042, 1, 'h0100);
    step("alloc_hit",    0, 'h0040,  0, 'h0000,  0, 'h0000,  0, 'h0000); pin(1, 'h0100, 0, 0); pin_cnt(1, 1);
    step("nt_1",         0, 'h0040,  1, 'h0040,  0, 'h0000,  1, 'h0100); pin(1, 'h0100, 1, 'h0042);
    step("nt_2",         0, 'h0040,  1, 'h0040,  0, 'h0000,  1, 'h0100); pin(0, 'h0042, 1, 'h0042);
    step("strong_nt",    0, 'h0040,  1, 'h0040,  1, 'h0100,  0, 'h0000); pin(0, 'h0042, 1, 'h0100);
    step("weak_nt",      0, 'h0040,  0, 'h0000,  0, 'h0000,  0, 'h0000); pin(0, 'h0042, 0, 0);
    step("alias_upd",    0, 'h0060,  1, 'h0060,  1, 'h0200,  0, 'h0000); pin(0, 'h0062, 1, 'h0200);
    step("alias_old",    0, 'h0040,  0, 'h0000,  0, 'h0000,  0, 'h0000); pin(0, 'h0042, 0, 0);
    step("alias_new",    0, 'h0060,  0, 'h0000,  0, 'h0000,  0, 'h0000); pin(1, 'h0200, 0, 0);
    step("same_idx",     0, 'h0060,  1, 'h0060,  1, 'h0300,  1, 'h0200); pin(1, 'h0200, 1, 'h0300);
    step("same_idx_nx",  0, 'h0060,  0, 'h0000,  0, 'h0000,  0, 'h0000); pin(1, 'h0300, 0, 0); pin_cnt(6, 6);
    step("rst_update",   1, 'h0080,  1, 'h0080,  1, 'h0400,  0, 'h0000);
    exp_q[exp_q.size()-1].fl = 1'b0;
    step("rst_no_alloc", 0, 'h0080,  0, 'h0000,  0, 'h0000,  0, 'h0000); pin(0, 'h0082, 0, 0); pin_cnt(0, 0);
    step("rst_cleared",  0, 'h0060,  0, 'h0000,  0, 'h0000,  0, 'h0000); pin(0, 'h0062, 0, 0);
    step("wrap",         0, 'hFFFE,  0, 'h0000,  0, 'h0000,  0, 'h0000); pin(0, 'h0000, 0, 0);

    // Random phase: 4 tags x 4 indices force aliasing and counter motion.
    for (int n = 0; n < 400; n++) begin
      int lpc, upc, tgt, ptgt;
      bit uv, ut, pt, rst;
      lpc = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 3) << 1);
      upc = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 3) << 1);
      if ($urandom_range(0, 15) == 0) upc = 'hFFFE;
      uv  = $urandom_range(0, 3) != 0;
      ut  = $urandom_range(0, 1);
      tgt = $urandom_range(0, 7) << 8;
      rst = $urandom_range(0, 63) == 0;
      if ($urandom_range(0, 9) < 7) predict(upc, pt, ptgt);
      else begin
        pt   = $urandom_range(0, 1);
        ptgt = $urandom_range(0, 7) << 8;
      end
      step("random", rst, lpc, uv, upc, ut, tgt, pt, ptgt);
    end

    @(posedge clk);
    #1;
    update_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
